// File: rtl/door_score_sched.sv
// Preference-score scheduler: 5-slot candidate window, serial MAC scan, best {slot,id} pushed to AFIFO.
// Optional stall-cycle counter on output stall_cycles when DOOR_SCHED_STALL_CNT_EN is defined.
module door_score_sched #(
  parameter int SLOTS   = 5,
  parameter int ID_W    = 5,
  parameter int DATA_W  = 8,
  parameter int W_W     = 3,
  parameter int OFFSET  = 5,
  parameter int NUM_REQ = 6000,
  localparam int IDX_W  = $clog2(SLOTS),
  localparam int CNT_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [ID_W-1:0]       doraemon_id,
  input  logic [DATA_W-1:0]     size,
  input  logic [DATA_W-1:0]     iq_score,
  input  logic [DATA_W-1:0]     eq_score,
  input  logic [W_W-1:0]        size_weight,
  input  logic [W_W-1:0]        iq_weight,
  input  logic [W_W-1:0]        eq_weight,
  input  logic                  wfull,
  output logic                  ready,
  output logic                  winc,
  output logic [IDX_W+ID_W-1:0] wdata,
`ifdef DOOR_SCHED_STALL_CNT_EN
  output logic [15:0]           stall_cycles,
`endif
  output logic                  done
);

  localparam int SC_W = DATA_W + W_W + 2;

  typedef enum logic [2:0] {S_FILL, S_IDLE, S_SCAN, S_EMIT, S_DONE} state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_fill_cnt;
  logic [IDX_W-1:0]  r_scan_idx;
  logic [IDX_W-1:0]  r_winner;
  logic [CNT_W-1:0]  r_req_cnt;
  logic [SC_W-1:0]   r_best;
  logic [W_W-1:0]    r_sw, r_iw, r_ew;
  logic [ID_W-1:0]   r_id [SLOTS];
  logic [DATA_W-1:0] r_s  [SLOTS];
  logic [DATA_W-1:0] r_i  [SLOTS];
  logic [DATA_W-1:0] r_e  [SLOTS];

  logic              w_acc;
  logic [IDX_W-1:0]  w_target;
  logic [SC_W-1:0]   w_score;

  assign ready    = (r_state == S_FILL) || (r_state == S_IDLE);
  assign w_acc    = in_valid && ready;
  assign w_target = (r_state == S_FILL) ? r_fill_cnt : r_winner;
  assign winc     = (r_state == S_EMIT) && !wfull;
  assign wdata    = (r_state == S_EMIT) ? {r_winner, r_id[r_winner]} : '0;
  assign done     = (r_state == S_DONE);

  assign w_score = SC_W'(r_s[r_scan_idx]) * SC_W'(r_sw)
                 + SC_W'(r_i[r_scan_idx]) * SC_W'(r_iw)
                 + SC_W'(r_e[r_scan_idx]) * SC_W'(r_ew);

  // Slot contents carry no reset; a fresh fill overwrites every slot before it is scanned.
  always_ff @(posedge clk) begin
    for (int k = 0; k < SLOTS; k++) begin
      if (w_acc && (w_target == IDX_W'(k))) begin
        r_id[k] <= doraemon_id;
        r_s[k]  <= size     - DATA_W'(OFFSET);
        r_i[k]  <= iq_score - DATA_W'(OFFSET);
        r_e[k]  <= eq_score - DATA_W'(OFFSET);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FILL;
      r_fill_cnt <= '0;
      r_scan_idx <= '0;
      r_winner   <= '0;
      r_best     <= '0;
      r_req_cnt  <= '0;
      r_sw       <= '0;
      r_iw       <= '0;
      r_ew       <= '0;
    end else begin
      if (w_acc) begin
        r_sw      <= size_weight;
        r_iw      <= iq_weight;
        r_ew      <= eq_weight;
        r_req_cnt <= r_req_cnt + CNT_W'(1);
      end
      case (r_state)
        S_FILL: begin
          if (w_acc) begin
            if (r_fill_cnt == IDX_W'(SLOTS-1)) begin
              r_state    <= S_SCAN;
              r_scan_idx <= '0;
              r_best     <= '0;
              r_winner   <= '0;
            end else begin
              r_fill_cnt <= r_fill_cnt + IDX_W'(1);
            end
          end
        end
        S_IDLE: begin
          // Winner is cleared here, after w_target has already used it to pick the overwrite slot.
          if (w_acc) begin
            r_state    <= S_SCAN;
            r_scan_idx <= '0;
            r_best     <= '0;
            r_winner   <= '0;
          end
        end
        S_SCAN: begin
          if (w_score > r_best) begin
            r_best   <= w_score;
            r_winner <= r_scan_idx;
          end
          if (r_scan_idx == IDX_W'(SLOTS-1)) r_state <= S_EMIT;
          else                               r_scan_idx <= r_scan_idx + IDX_W'(1);
        end
        S_EMIT: begin
          if (!wfull) r_state <= (r_req_cnt == CNT_W'(NUM_REQ)) ? S_DONE : S_IDLE;
        end
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_FILL;
      endcase
    end
  end

`ifdef DOOR_SCHED_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                                   stall_cycles <= '0;
    else if (r_state == S_EMIT && wfull && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule
